wb_coef_ctrl: RTL and testbench

- Slave end of the white balance control interface (wb_ctrl_if, slave modport).
- Takes mode, calibration strobe and manual writes from the CSR master and keeps the per-channel R/G/B gain coefficients for the white balance corrector datapath.
- Auto and calibration modes compute gray-world gains (G_sum/R_sum, G_sum/B_sum) from per-frame channel sums, using a sequential divider.
- Coefficients change only at frame start, and the active value of the selected channel is returned on cur_coef.

---
 rtl/wb_ctrl_pkg.sv | 30 +++
 rtl/wb_ctrl_if.sv | 12 +
 rtl/wb_seq_div.sv | 72 +++++++
 rtl/wb_coef_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_wb_coef_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared types and constants for the white balance coefficient controller.
package wb_ctrl_pkg;

  typedef enum logic [1:0] {
    WB_BYPASS = 2'd0,
    WB_AUTO   = 2'd1,
    WB_CAL    = 2'd2,
    WB_MANUAL = 2'd3
  } wb_mode_e;

  typedef enum logic [1:0] {
    WB_CH_R    = 2'd0,
    WB_CH_G    = 2'd1,
    WB_CH_B    = 2'd2,
    WB_CH_RSVD = 2'd3
  } wb_chan_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV_R = 2'd1,
    ST_DIV_B = 2'd2,
    ST_LOAD  = 2'd3
  } wb_state_e;

  // Unity gain in a fixed-point format with frac_width fractional bits.
  function automatic logic [31:0] unity_coef(input int unsigned frac_width);
    return 32'd1 << frac_width;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Control interface between the CSR block (master) and the coefficient controller (slave).
interface wb_ctrl_if;
  logic [1:0]  mode;
  logic        cal_stb;
  logic [1:0]  man_sel;
  logic [31:0] man_coef;
  logic        man_lock;
  logic [31:0] cur_coef;

  modport master (output mode, cal_stb, man_sel, man_coef, man_lock, input cur_coef);
  modport slave  (input mode, cal_stb, man_sel, man_coef, man_lock, output cur_coef);
endinterface

// File: rtl/wb_seq_div.sv
// Restoring unsigned divider: (dividend << SHIFT) / divisor, one quotient bit per
// cycle. o_done and o_quot are valid combinationally on the last iteration cycle;
// the quotient saturates to all ones on overflow or a zero divisor.
module wb_seq_div #(
  parameter int DVD_WIDTH = 32,
  parameter int SHIFT     = 12,
  parameter int Q_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_start,
  input  logic [DVD_WIDTH-1:0] i_dividend,
  input  logic [DVD_WIDTH-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_dz,
  output logic [Q_WIDTH-1:0]   o_quot
);
  localparam int N     = DVD_WIDTH + SHIFT;
  localparam int CNT_W = $clog2(N);

  logic                 r_busy;
  logic [CNT_W-1:0]     r_cnt;
  logic [DVD_WIDTH-1:0] r_rem;
  logic [DVD_WIDTH-1:0] r_dvs;
  logic [N-1:0]         r_quo;

  logic [DVD_WIDTH:0]   w_shift;
  logic [DVD_WIDTH-1:0] w_diff;
  logic                 w_ge;
  logic [DVD_WIDTH-1:0] w_rem_next;
  logic [N-1:0]         w_quo_next;
  logic                 w_last;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    w_shift    = {r_rem, r_quo[N-1]};
    w_ge       = (w_shift >= {1'b0, r_dvs});
    w_diff     = w_shift[DVD_WIDTH-1:0] - r_dvs;
    w_rem_next = w_ge ? w_diff : w_shift[DVD_WIDTH-1:0];
    w_quo_next = {r_quo[N-2:0], w_ge};
    w_last     = r_busy && (r_cnt == CNT_W'(N - 1));
  end

  // Iteration state; the dividend register shifts out as quotient bits shift in.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      r_quo  <= {i_dividend, {SHIFT{1'b0}}};
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_last;
  assign o_dz   = (r_dvs == '0);
  assign o_quot = (o_dz || (|w_quo_next[N-1:Q_WIDTH])) ? '1 : w_quo_next[Q_WIDTH-1:0];

endmodule

// File: rtl/wb_coef_ctrl.sv
// White balance coefficient controller (slave side of wb_ctrl_if).
// Computes gray-world gains in auto/calibrate modes, holds manual gains, and
// applies the selected set at start of frame.
// Optional: define WB_COEF_CLAMP_EN to clamp computed R/B gains to [COEF_MIN, COEF_MAX].
module wb_coef_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_WIDTH = 12
`ifdef WB_COEF_CLAMP_EN
  ,
  parameter int COEF_MIN   = 1024,
  parameter int COEF_MAX   = 16383
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_ctrl_if.slave              ctrl_if,
  input  logic                  sof_i,
  input  logic                  stat_valid_i,
  input  logic [ACC_WIDTH-1:0]  stat_r_i,
  input  logic [ACC_WIDTH-1:0]  stat_g_i,
  input  logic [ACC_WIDTH-1:0]  stat_b_i,
  output logic [COEF_WIDTH-1:0] coef_r_o,
  output logic [COEF_WIDTH-1:0] coef_g_o,
  output logic [COEF_WIDTH-1:0] coef_b_o,
  output logic                  coef_upd_o
);
  localparam logic [COEF_WIDTH-1:0] UNITY = COEF_WIDTH'(unity_coef(FRAC_WIDTH));

  // Computed gain post-processing applied when the pending set is written.
  function automatic logic [COEF_WIDTH-1:0] f_gain(input logic [COEF_WIDTH-1:0] v);
`ifdef WB_COEF_CLAMP_EN
    if (int'(v) < COEF_MIN) return COEF_WIDTH'(COEF_MIN);
    if (int'(v) > COEF_MAX) return COEF_WIDTH'(COEF_MAX);
`endif
    return v;
  endfunction

  wb_state_e r_state, w_state_next;
  logic w_capture, w_div_start, w_load;

  logic [ACC_WIDTH-1:0]  r_sum_g, r_sum_b;
  logic [COEF_WIDTH-1:0] r_div_r, r_div_b;
  logic [COEF_WIDTH-1:0] r_pend_r, r_pend_b;
  logic [COEF_WIDTH-1:0] r_man_r, r_man_g, r_man_b;
  logic [COEF_WIDTH-1:0] r_coef_r, r_coef_g, r_coef_b;
  logic [COEF_WIDTH-1:0] w_nxt_r, w_nxt_g, w_nxt_b;
  logic                  r_pend_valid, r_cal_arm, r_cal_done, r_cap_cal;
  logic                  r_lock_q, r_coef_upd;
  logic [31:0]           r_cur;

  logic                  w_div_busy, w_div_done, w_div_dz;
  logic [COEF_WIDTH-1:0] w_div_quot, w_div_q;
  logic [ACC_WIDTH-1:0]  w_div_dividend, w_div_divisor;

  // The R division is launched straight from the stat inputs so DIV_R spans
  // exactly the iteration count; the B division reuses the latched sums.
  assign w_div_dividend = (r_state == ST_IDLE) ? stat_g_i : r_sum_g;
  assign w_div_divisor  = (r_state == ST_IDLE) ? stat_r_i : r_sum_b;
  assign w_div_q        = w_div_dz ? '1 : w_div_quot;

  wb_seq_div #(
    .DVD_WIDTH (ACC_WIDTH),
    .SHIFT     (FRAC_WIDTH),
    .Q_WIDTH   (COEF_WIDTH)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_start    (w_div_start),
    .i_dividend (w_div_dividend),
    .i_divisor  (w_div_divisor),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_dz       (w_div_dz),
    .o_quot     (w_div_quot)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state and control strobes.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_div_start  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (stat_valid_i && !w_div_busy &&
            ((wb_mode_e'(ctrl_if.mode) == WB_AUTO) || r_cal_arm || ctrl_if.cal_stb)) begin
          w_capture    = 1'b1;
          w_div_start  = 1'b1;
          w_state_next = ST_DIV_R;
        end
      end
      ST_DIV_R: begin
        if (w_div_done) begin
          w_div_start  = 1'b1;
          w_state_next = ST_DIV_B;
        end
      end
      ST_DIV_B: if (w_div_done) w_state_next = ST_LOAD;
      ST_LOAD: begin
        w_load       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Capture, division results, pending set and calibration bookkeeping.
  // Order matters: a cal_stb overrides a LOAD's cal_done, a capture consumes cal_arm.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sum_g      <= '0;
      r_sum_b      <= '0;
      r_div_r      <= UNITY;
      r_div_b      <= UNITY;
      r_pend_r     <= UNITY;
      r_pend_b     <= UNITY;
      r_pend_valid <= 1'b0;
      r_cal_arm    <= 1'b0;
      r_cal_done   <= 1'b0;
      r_cap_cal    <= 1'b0;
    end else begin
      if (r_state == ST_DIV_R && w_div_done) r_div_r <= w_div_q;
      if (r_state == ST_DIV_B && w_div_done) r_div_b <= w_div_q;
      if (sof_i) r_pend_valid <= 1'b0;
      if (w_load) begin
        r_pend_r     <= f_gain(r_div_r);
        r_pend_b     <= f_gain(r_div_b);
        r_pend_valid <= 1'b1;
        if (r_cap_cal) r_cal_done <= 1'b1;
      end
      if (ctrl_if.cal_stb) begin
        r_cal_arm  <= 1'b1;
        r_cal_done <= 1'b0;
        r_cap_cal  <= 1'b0;
      end
      if (w_capture) begin
        r_sum_g   <= stat_g_i;
        r_sum_b   <= stat_b_i;
        r_cap_cal <= r_cal_arm | ctrl_if.cal_stb;
        r_cal_arm <= 1'b0;
      end
    end
  end

  // Manual register writes on a rising edge of man_lock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lock_q <= 1'b0;
      r_man_r  <= UNITY;
      r_man_g  <= UNITY;
      r_man_b  <= UNITY;
    end else begin
      r_lock_q <= ctrl_if.man_lock;
      if (ctrl_if.man_lock && !r_lock_q) begin
        case (wb_chan_e'(ctrl_if.man_sel))
          WB_CH_R: r_man_r <= ctrl_if.man_coef[COEF_WIDTH-1:0];
          WB_CH_G: r_man_g <= ctrl_if.man_coef[COEF_WIDTH-1:0];
          WB_CH_B: r_man_b <= ctrl_if.man_coef[COEF_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Source selection for the active set at the next start of frame.
  always_comb begin
    w_nxt_r = r_coef_r;
    w_nxt_g = r_coef_g;
    w_nxt_b = r_coef_b;
    case (wb_mode_e'(ctrl_if.mode))
      WB_BYPASS: begin
        w_nxt_r = UNITY; w_nxt_g = UNITY; w_nxt_b = UNITY;
      end
      WB_AUTO: begin
        if (r_pend_valid) begin
          w_nxt_r = r_pend_r; w_nxt_g = UNITY; w_nxt_b = r_pend_b;
        end
      end
      WB_CAL: begin
        if (!r_cal_done) begin
          w_nxt_r = UNITY; w_nxt_g = UNITY; w_nxt_b = UNITY;
        end else if (r_pend_valid) begin
          w_nxt_r = r_pend_r; w_nxt_g = UNITY; w_nxt_b = r_pend_b;
        end
      end
      WB_MANUAL: begin
        w_nxt_r = r_man_r; w_nxt_g = r_man_g; w_nxt_b = r_man_b;
      end
      default: ;
    endcase
  end

  // Active set update at start of frame, with a change pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_coef_r   <= UNITY;
      r_coef_g   <= UNITY;
      r_coef_b   <= UNITY;
      r_coef_upd <= 1'b0;
    end else if (sof_i) begin
      r_coef_r   <= w_nxt_r;
      r_coef_g   <= w_nxt_g;
      r_coef_b   <= w_nxt_b;
      r_coef_upd <= (w_nxt_r != r_coef_r) || (w_nxt_g != r_coef_g) || (w_nxt_b != r_coef_b);
    end else begin
      r_coef_upd <= 1'b0;
    end
  end

  // Registered readback of the active coefficient picked by man_sel.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cur <= 32'(UNITY);
    end else begin
      case (wb_chan_e'(ctrl_if.man_sel))
        WB_CH_R: r_cur <= 32'(r_coef_r);
        WB_CH_G: r_cur <= 32'(r_coef_g);
        WB_CH_B: r_cur <= 32'(r_coef_b);
        default: r_cur <= '0;
      endcase
    end
  end

  assign ctrl_if.cur_coef = r_cur;
  assign coef_r_o         = r_coef_r;
  assign coef_g_o         = r_coef_g;
  assign coef_b_o         = r_coef_b;
  assign coef_upd_o       = r_coef_upd;

endmodule

// File: tb/tb_wb_coef_ctrl.sv
// Self-checking bench for wb_coef_ctrl with a frame-level reference model.
module tb_wb_coef_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        sof_i = 1'b0;
  logic        stat_valid_i = 1'b0;
  logic [31:0] stat_r_i = '0, stat_g_i = '0, stat_b_i = '0;
  logic [15:0] coef_r_o, coef_g_o, coef_b_o;
  logic        coef_upd_o;

  wb_ctrl_if u_if ();

  wb_coef_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ctrl_if      (u_if),
    .sof_i        (sof_i),
    .stat_valid_i (stat_valid_i),
    .stat_r_i     (stat_r_i),
    .stat_g_i     (stat_g_i),
    .stat_b_i     (stat_b_i),
    .coef_r_o     (coef_r_o),
    .coef_g_o     (coef_g_o),
    .coef_b_o     (coef_b_o),
    .coef_upd_o   (coef_upd_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level reference model.
  logic [15:0] m_act [3];
  logic [15:0] m_pend[3];
  logic [15:0] m_man [3];
  bit          m_pv, m_arm, m_done, m_upd;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 16'd4096; m_pend[i] = 16'd4096; m_man[i] = 16'd4096;
    end
    m_pv = 0; m_arm = 0; m_done = 0; m_upd = 0;
  endtask

  // Gray-world gain: (num * 4096) / den, saturated to 16 bits.
  function automatic logic [15:0] m_gain(input logic [31:0] num, input logic [31:0] den);
    longint unsigned q;
    if (den == 0) q = 65535;
    else q = (64'(num) * 64'd4096) / 64'(den);
    if (q > 65535) q = 65535;
`ifdef WB_COEF_CLAMP_EN
    if (q < 1024) q = 1024;
    if (q > 16383) q = 16383;
`endif
    return q[15:0];
  endfunction

  task automatic m_stat(input logic [31:0] r, g, b, input bit stb);
    if (stb) begin m_arm = 1; m_done = 0; end
    if (u_if.mode == 2'd1 || m_arm) begin
      m_pend[0] = m_gain(g, r);
      m_pend[1] = 16'd4096;
      m_pend[2] = m_gain(g, b);
      m_pv = 1;
      if (m_arm) m_done = 1;
      m_arm = 0;
    end
  endtask

  task automatic m_sof();
    logic [15:0] n[3];
    for (int i = 0; i < 3; i++) n[i] = m_act[i];
    case (u_if.mode)
      2'd0: for (int i = 0; i < 3; i++) n[i] = 16'd4096;
      2'd1: if (m_pv) for (int i = 0; i < 3; i++) n[i] = m_pend[i];
      2'd2: begin
        if (!m_done) for (int i = 0; i < 3; i++) n[i] = 16'd4096;
        else if (m_pv) for (int i = 0; i < 3; i++) n[i] = m_pend[i];
      end
      default: for (int i = 0; i < 3; i++) n[i] = m_man[i];
    endcase
    m_upd = (n[0] != m_act[0]) || (n[1] != m_act[1]) || (n[2] != m_act[2]);
    for (int i = 0; i < 3; i++) m_act[i] = n[i];
    m_pv = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Drive one stat pulse; model_it=0 for frames the DUT must drop.
  task automatic pulse_stat(input logic [31:0] r, g, b, input bit stb, input bit model_it);
    stat_r_i = r; stat_g_i = g; stat_b_i = b;
    stat_valid_i = 1'b1; u_if.cal_stb = stb;
    tick();
    stat_valid_i = 1'b0; u_if.cal_stb = 1'b0;
    if (model_it) m_stat(r, g, b, stb);
  endtask

  task automatic pulse_sof();
    sof_i = 1'b1;
    tick();
    sof_i = 1'b0;
    m_sof();
  endtask

  task automatic test_reset();
    tick(3);
    rst_i = 1'b1;
    m_reset();
    tick();
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {16'd4096, 16'd4096, 16'd4096}) begin
      n_err++; $display("FAIL reset_coefs got %0d/%0d/%0d want 4096/4096/4096", coef_r_o, coef_g_o, coef_b_o);
    end
    n_vec++;
    if (coef_upd_o !== 1'b0 || u_if.cur_coef !== 32'd4096) begin
      n_err++; $display("FAIL reset_upd_cur got upd=%0b cur=%0d want upd=0 cur=4096", coef_upd_o, u_if.cur_coef);
    end
  endtask

  task automatic test_auto();
    logic [31:0] r, g, b;
    u_if.mode = 2'd1;
    for (int it = 0; it < 8; it++) begin
      case (it)
        0: begin r = 1000; g = 2000; b = 4000; end
        1: begin r = 1; g = 32'd1 << 20; b = 0; end
        default: begin
          r = $urandom_range(0, 5) == 0 ? 32'd0 : $urandom_range(1, 1 << 20);
          g = $urandom_range(1, 1 << 20);
          b = $urandom_range(1, 1 << 21);
        end
      endcase
      pulse_stat(r, g, b, 1'b0, 1'b1);
      tick(100);
      pulse_sof();
      n_vec++;
      if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]}) begin
        n_err++; $display("FAIL auto_coefs it=%0d sums=%0d/%0d/%0d got %0d/%0d/%0d want %0d/%0d/%0d",
          it, r, g, b, coef_r_o, coef_g_o, coef_b_o, m_act[0], m_act[1], m_act[2]);
      end
      n_vec++;
      if (coef_upd_o !== m_upd) begin
        n_err++; $display("FAIL auto_upd it=%0d got %0b want %0b", it, coef_upd_o, m_upd);
      end
      tick();
      n_vec++;
      if (coef_upd_o !== 1'b0 || u_if.cur_coef !== 32'(m_act[0])) begin
        n_err++; $display("FAIL auto_cur it=%0d got upd=%0b cur=%0d want upd=0 cur=%0d", it, coef_upd_o, u_if.cur_coef, m_act[0]);
      end
    end
  endtask

  task automatic test_cal();
    logic [31:0] r, g, b;
    u_if.mode = 2'd2;
    for (int it = 0; it < 5; it++) begin
      case (it)
        0: begin pulse_stat(3000, 1000, 500, 1'b0, 1'b1); end
        1: begin
          u_if.cal_stb = 1'b1; tick(); u_if.cal_stb = 1'b0;
          m_arm = 1; m_done = 0;
          pulse_stat(2000, 2000, 1000, 1'b0, 1'b1);
        end
        2: pulse_stat(777, 5000, 9999, 1'b0, 1'b1);
        3: begin
          r = $urandom_range(500, 9000); g = $urandom_range(500, 9000); b = $urandom_range(500, 9000);
          pulse_stat(r, g, b, 1'b1, 1'b1);
        end
        default: begin
          u_if.cal_stb = 1'b1; tick(); u_if.cal_stb = 1'b0;
          m_arm = 1; m_done = 0;
        end
      endcase
      tick(100);
      pulse_sof();
      n_vec++;
      if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]} || coef_upd_o !== m_upd) begin
        n_err++; $display("FAIL cal_coefs it=%0d got %0d/%0d/%0d upd=%0b want %0d/%0d/%0d upd=%0b",
          it, coef_r_o, coef_g_o, coef_b_o, coef_upd_o, m_act[0], m_act[1], m_act[2], m_upd);
      end
    end
  endtask

  task automatic test_manual();
    logic [1:0]  s;
    logic [31:0] c;
    u_if.mode = 2'd3;
    u_if.man_sel = 2'd2; u_if.man_coef = 32'h1800; u_if.man_lock = 1'b1;
    tick();
    m_man[2] = 16'h1800;
    u_if.man_coef = 32'h2222;
    tick(3);
    u_if.man_lock = 1'b0;
    tick();
    n_vec++;
    if (coef_b_o !== m_act[2]) begin
      n_err++; $display("FAIL man_before_sof got %0d want %0d", coef_b_o, m_act[2]);
    end
    pulse_sof();
    tick();
    n_vec++;
    if (coef_b_o !== 16'd6144 || coef_b_o !== m_act[2] || u_if.cur_coef !== 32'h1800) begin
      n_err++; $display("FAIL man_hold_lock got coef_b=%0d cur=%0h want 6144 cur=1800", coef_b_o, u_if.cur_coef);
    end
    for (int it = 0; it < 8; it++) begin
      s = 2'($urandom_range(0, 3)); c = $urandom;
      u_if.man_sel = s; u_if.man_coef = c; u_if.man_lock = 1'b1;
      tick();
      u_if.man_lock = 1'b0;
      tick();
      if (s != 2'd3) m_man[s] = c[15:0];
      pulse_sof();
      n_vec++;
      if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]} || coef_upd_o !== m_upd) begin
        n_err++; $display("FAIL man_rand it=%0d sel=%0d got %0d/%0d/%0d upd=%0b want %0d/%0d/%0d upd=%0b",
          it, s, coef_r_o, coef_g_o, coef_b_o, coef_upd_o, m_act[0], m_act[1], m_act[2], m_upd);
      end
      s = 2'($urandom_range(0, 3));
      u_if.man_sel = s;
      tick();
      n_vec++;
      if (u_if.cur_coef !== ((s == 2'd3) ? 32'd0 : 32'(m_act[s]))) begin
        n_err++; $display("FAIL man_cur it=%0d sel=%0d got %0d want %0d", it, s, u_if.cur_coef,
          (s == 2'd3) ? 32'd0 : 32'(m_act[s]));
      end
    end
  endtask

  task automatic test_drop_and_mode();
    u_if.mode = 2'd1;
    pulse_stat(1500, 4500, 3000, 1'b0, 1'b1);
    tick(10);
    pulse_stat(10, 9000, 20, 1'b0, 1'b0);
    tick(100);
    pulse_sof();
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]}) begin
      n_err++; $display("FAIL drop_busy got %0d/%0d/%0d want %0d/%0d/%0d",
        coef_r_o, coef_g_o, coef_b_o, m_act[0], m_act[1], m_act[2]);
    end
    pulse_stat(1000, 5000, 2500, 1'b0, 1'b1);
    tick(100);
    u_if.mode = 2'd0;
    tick(5);
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]} || coef_upd_o !== 1'b0) begin
      n_err++; $display("FAIL mode_before_sof got %0d/%0d/%0d want %0d/%0d/%0d",
        coef_r_o, coef_g_o, coef_b_o, m_act[0], m_act[1], m_act[2]);
    end
    pulse_sof();
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {16'd4096, 16'd4096, 16'd4096} || coef_upd_o !== m_upd) begin
      n_err++; $display("FAIL mode_bypass got %0d/%0d/%0d upd=%0b want 4096/4096/4096 upd=%0b",
        coef_r_o, coef_g_o, coef_b_o, coef_upd_o, m_upd);
    end
  endtask

  task automatic test_reset_mid_div();
    u_if.mode = 2'd1;
    pulse_stat(1000, 3000, 500, 1'b0, 1'b1);
    tick(100);
    pulse_sof();
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]}) begin
      n_err++; $display("FAIL rstdiv_setup got %0d/%0d/%0d want %0d/%0d/%0d",
        coef_r_o, coef_g_o, coef_b_o, m_act[0], m_act[1], m_act[2]);
    end
    pulse_stat(4000, 1000, 8000, 1'b0, 1'b0);
    tick(60);
    rst_i = 1'b0;
    #1;
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {16'd4096, 16'd4096, 16'd4096} || coef_upd_o !== 1'b0) begin
      n_err++; $display("FAIL rstdiv_async got %0d/%0d/%0d upd=%0b want 4096/4096/4096 upd=0",
        coef_r_o, coef_g_o, coef_b_o, coef_upd_o);
    end
    tick(2);
    rst_i = 1'b1;
    m_reset();
    tick(100);
    pulse_sof();
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]} || coef_upd_o !== m_upd) begin
      n_err++; $display("FAIL rstdiv_stale got %0d/%0d/%0d upd=%0b want %0d/%0d/%0d upd=%0b",
        coef_r_o, coef_g_o, coef_b_o, coef_upd_o, m_act[0], m_act[1], m_act[2], m_upd);
    end
    u_if.mode = 2'd3;
    pulse_sof();
    n_vec++;
    if ({coef_r_o, coef_g_o, coef_b_o} !== {m_act[0], m_act[1], m_act[2]} || coef_upd_o !== m_upd) begin
      n_err++; $display("FAIL rstdiv_manual got %0d/%0d/%0d upd=%0b want %0d/%0d/%0d upd=%0b",
        coef_r_o, coef_g_o, coef_b_o, coef_upd_o, m_act[0], m_act[1], m_act[2], m_upd);
    end
  endtask

  initial begin
    u_if.mode = 2'd0; u_if.cal_stb = 1'b0; u_if.man_sel = 2'd0;
    u_if.man_coef = '0; u_if.man_lock = 1'b0;
    m_reset();
    test_reset();
    test_auto();
    test_cal();
    test_manual();
    test_drop_and_mode();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
